// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-stage SRAM controller.
//   state_e       : access sequencer states
//   DEF_*         : default parameter values for the controller
//   HALF_W        : SRAM data bus width (one half of a 32-bit word)
//   CNT_W         : width of the per-half wait counter
package mem_stage_pkg;

  localparam int DEF_BASE_ADDR = 1024;
  localparam int DEF_SRAM_WAIT = 2;
  localparam int DEF_SRAM_AW   = 18;
  localparam int HALF_W        = 16;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half access timer for the SRAM controller.
// Counts up from zero every cycle unless cleared; last flags the final
// cycle of a half-word access.
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   clear in  force the count back to zero on the next edge
//   limit in  cycles per half access (1..15)
//   last  out count has reached limit-1
module sram_wait_counter
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = clear ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == limit - CNT_W'(1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage of the 5-stage pipeline: splits each 32-bit load/store into
// two 16-bit SRAM accesses (low half, then high half) and holds ready low
// while busy so the pipeline freezes.
//
// State   | meaning
// --------+-------------------------------------------------------
// IDLE    | no access; ready mirrors absence of a request
// LOW     | half-word 0 on the bus for SRAM_WAIT cycles
// HIGH    | half-word 1 on the bus for SRAM_WAIT cycles
// DONE    | single ready cycle so EX/MEM advances past the request
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   mem_r_en/w_en    load/store request from EX/MEM (store wins if both)
//   alu_res, val_rm  byte address and store data
//   ready            high = pipeline may advance
//   mem_rdata        assembled load data
//   alu_res_out      alu_res passed straight through
//   sram_*           half-word address, write data, bus drive enable,
//                    read data from pad, active-low write strobe
//   misalign         (MEM_ALIGN_CHECK_EN only) flags the DONE cycle of an
//                    access with a nonzero byte offset
module mem_stage_sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int BASE_ADDR = DEF_BASE_ADDR,
  parameter int SRAM_WAIT = DEF_SRAM_WAIT,
  parameter int SRAM_AW   = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        val_rm,
  output logic               ready,
  output logic [31:0]        mem_rdata,
  output logic [31:0]        alu_res_out,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HALF_W-1:0]  sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [HALF_W-1:0]  sram_dq_in,
  output logic               sram_we_n
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic               misalign
`endif
);

  localparam logic [31:0]      BASE_L = 32'(BASE_ADDR);
  localparam logic [CNT_W-1:0] WAIT_L = CNT_W'(SRAM_WAIT);

  state_e             state_q, state_d;
  logic [31:0]        mem_rdata_q, mem_rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [HALF_W-1:0]  sram_dq_out_q, sram_dq_out_d;
  logic               sram_dq_oe_q, sram_dq_oe_d;
  logic               sram_we_n_q, sram_we_n_d;

  logic               req;
  logic               is_store;
  logic               is_load;
  logic               cnt_clear;
  logic               wait_last;
  logic [SRAM_AW-2:0] word;

  assign req      = mem_r_en | mem_w_en;
  assign is_store = mem_w_en;
  assign is_load  = mem_r_en & ~mem_w_en;

  // Wraparound byte offset from the data-memory base, reduced to a word index;
  // the byte-in-word bits are dropped.
  assign word = (SRAM_AW-1)'((alu_res - BASE_L) >> 2);

  assign alu_res_out = alu_res;

  sram_wait_counter u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .limit (WAIT_L),
    .last  (wait_last)
  );

  always_comb begin
    state_d       = state_q;
    mem_rdata_d   = mem_rdata_q;
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = 1'b0;
    sram_we_n_d   = 1'b1;
    ready         = 1'b0;
    cnt_clear     = 1'b1;

    case (state_q)
      ST_IDLE: begin
        // Combinational so the stall lands in the same cycle as the request.
        ready = ~req;
        if (req) state_d = ST_LOW;
      end
      ST_LOW: begin
        cnt_clear = wait_last;
        if (wait_last) begin
          if (is_load) mem_rdata_d[HALF_W-1:0] = sram_dq_in;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        cnt_clear = wait_last;
        if (wait_last) begin
          if (is_load) mem_rdata_d[31:HALF_W] = sram_dq_in;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus outputs are registered from the next state so the strobes come
    // straight off flops and drop cleanly on reset.
    if (state_d == ST_LOW || state_d == ST_HIGH) begin
      sram_addr_d = {word, state_d == ST_HIGH};
      if (is_store) begin
        sram_we_n_d   = 1'b0;
        sram_dq_oe_d  = 1'b1;
        sram_dq_out_d = (state_d == ST_HIGH) ? val_rm[31:HALF_W] : val_rm[HALF_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_rdata_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      mem_rdata_q   <= mem_rdata_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

  assign mem_rdata   = mem_rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = (state_d == ST_DONE) && (alu_res[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
module tb_mem_stage_sram_ctrl;

`ifdef MEM_ALIGN_CHECK_EN
  localparam int W = 1;
`else
  localparam int W = 2;
`endif
  localparam int BASE  = 1024;
  localparam int STALL = 1 + 2 * W;
  localparam int DEPTH = 262144;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_rm;
  logic        ready;
  logic [31:0] mem_rdata, alu_res_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int errors = 0;
  int checks = 0;
  int writes = 0;
  logic [15:0] sram    [DEPTH];
  logic [15:0] ref_mem [DEPTH];
  logic [31:0] rd_model;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.BASE_ADDR(BASE), .SRAM_WAIT(W), .SRAM_AW(18)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_r_en    (mem_r_en),
    .mem_w_en    (mem_w_en),
    .alu_res     (alu_res),
    .val_rm      (val_rm),
    .ready       (ready),
    .mem_rdata   (mem_rdata),
    .alu_res_out (alu_res_out),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign    (misalign)
`endif
  );

  // External SRAM: asynchronous read, write sampled on each strobed edge.
  assign sram_dq_in = sram_dq_oe ? 16'h0000 : sram[sram_addr];
  always @(posedge clk) begin
    if (!rst && !sram_we_n) begin
      sram[sram_addr] = sram_dq_out;
      writes++;
    end
  end

  // One full access from request to the DONE cycle; returns just after the
  // edge leaving DONE with the request still applied.
  task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] d, input string tag);
    logic [16:0] word;
    logic [31:0] exp_rd;
    logic        load;
    logic        half;
    bit          done;
    int          c;
    word   = 17'((a - 32'(BASE)) >> 2);
    load   = r & ~w;
    exp_rd = load ? {ref_mem[{word, 1'b1}], ref_mem[{word, 1'b0}]} : rd_model;
    mem_w_en = w; mem_r_en = r; alu_res = a; val_rm = d;
    c = 0; done = 0;
    while (!done && c < 64) begin
      @(negedge clk);
      if (ready) done = 1;
      else begin
        checks++;
        if (c == 0) begin
          if ({sram_we_n, sram_dq_oe} !== 2'b10) begin
            errors++;
            $display("FAIL %s req_cycle_bus: we_n/oe=%b%b expected 10", tag, sram_we_n, sram_dq_oe);
          end
        end else begin
          half = (c > W);
          if ({sram_we_n, sram_dq_oe, sram_addr} !== {~w, w, word, half}) begin
            errors++;
            $display("FAIL %s stall_bus c=%0d: we_n=%b oe=%b addr=%h expected we_n=%b oe=%b addr=%h",
                     tag, c, sram_we_n, sram_dq_oe, sram_addr, ~w, w, {word, half});
          end
          if (w) begin
            checks++;
            if (sram_dq_out !== (half ? d[31:16] : d[15:0])) begin
              errors++;
              $display("FAIL %s dq_out c=%0d: got %h expected %h", tag, c, sram_dq_out,
                       half ? d[31:16] : d[15:0]);
            end
          end
        end
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (misalign !== 1'b0) begin
          errors++;
          $display("FAIL %s misalign_stall c=%0d: got %b expected 0", tag, c, misalign);
        end
`endif
        c++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: ready never returned after %0d cycles", tag, c);
    end else begin
      if (c !== STALL) begin
        errors++;
        $display("FAIL %s stall_len: got %0d expected %0d", tag, c, STALL);
      end
      checks++;
      if (mem_rdata !== exp_rd) begin
        errors++;
        $display("FAIL %s rdata: got %h expected %h", tag, mem_rdata, exp_rd);
      end
      checks++;
      if ({sram_we_n, sram_dq_oe} !== 2'b10) begin
        errors++;
        $display("FAIL %s done_bus: we_n/oe=%b%b expected 10", tag, sram_we_n, sram_dq_oe);
      end
`ifdef MEM_ALIGN_CHECK_EN
      checks++;
      if (misalign !== (a[1:0] != 2'b00)) begin
        errors++;
        $display("FAIL %s misalign_done: got %b expected %b", tag, misalign, a[1:0] != 2'b00);
      end
`endif
    end
    if (w) begin
      ref_mem[{word, 1'b0}] = d[15:0];
      ref_mem[{word, 1'b1}] = d[31:16];
    end
    if (load) rd_model = exp_rd;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    mem_w_en = 0; mem_r_en = 0;
    repeat (n) begin
      @(negedge clk);
      checks++;
      if ({ready, sram_we_n, sram_dq_oe} !== 3'b110) begin
        errors++;
        $display("FAIL idle: ready/we_n/oe=%b%b%b expected 110", ready, sram_we_n, sram_dq_oe);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1; mem_w_en = 0; mem_r_en = 0; alu_res = 32'h1234; val_rm = 0;
    #1;
    checks++;
    if ({ready, mem_rdata, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n} !== {1'b1, 32'h0, 18'h0, 16'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_vals: ready=%b rdata=%h addr=%h dq=%h oe=%b we_n=%b", ready, mem_rdata,
               sram_addr, sram_dq_out, sram_dq_oe, sram_we_n);
    end
    checks++;
    if (alu_res_out !== 32'h1234) begin
      errors++;
      $display("FAIL passthru: got %h expected 00001234", alu_res_out);
    end
    mem_w_en = 1; #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_comb: got %b expected 0", ready);
    end
    mem_w_en = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    rd_model = 32'h0;
  endtask

  task automatic test_no_request();
    idle(10);
  endtask

  task automatic test_store_default();
    do_access(1, 0, 32'd1032, 32'hDEADBEEF, "store_default");
    idle(1);
  endtask

  task automatic test_load_default();
    do_access(0, 1, 32'd1032, 32'h0, "load_default");
    checks++;
    if (rd_model !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_default_value: got %h expected deadbeef", rd_model);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = writes;
    do_access(1, 0, 32'd1024 + 32'd40, 32'hCAFE_F00D, "b2b_store");
    checks++;
    if (writes - w0 !== 2 * W) begin
      errors++;
      $display("FAIL b2b_store_writes: got %0d expected %0d", writes - w0, 2 * W);
    end
    w0 = writes;
    do_access(0, 1, 32'd1024 + 32'd40, 32'h0, "b2b_load");
    checks++;
    if (writes - w0 !== 0) begin
      errors++;
      $display("FAIL b2b_load_writes: got %0d expected 0", writes - w0);
    end
    do_access(1, 1, 32'd1024 + 32'd40, 32'h1111_2222, "b2b_both");
    do_access(0, 1, 32'd1024 + 32'd40, 32'h0, "b2b_reload");
    idle(1);
  endtask

  task automatic test_wraparound();
    do_access(1, 0, 32'd1020, 32'hA5A5_5A5A, "wrap_store");
    do_access(0, 1, 32'd1020, 32'h0, "wrap_load");
    idle(1);
  endtask

  task automatic test_random();
    int op;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      a  = 32'(BASE + 4 * $urandom_range(16, 47) + $urandom_range(0, 3));
      do_access(op != 1, op != 0, a, $urandom, "random");
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    int target;
    target = (W >= 2) ? W + 2 : W + 1;
    mem_w_en = 1; mem_r_en = 0; alu_res = 32'(BASE + 4 * 5000); val_rm = 32'h1234_5678;
    repeat (target + 1) @(negedge clk);
    checks++;
    if (sram_we_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre: we_n=%b expected 0", sram_we_n);
    end
    rst = 1; #1;
    checks++;
    if ({sram_we_n, sram_dq_oe, mem_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid_same_cycle: we_n=%b oe=%b rdata=%h expected 1 0 0", sram_we_n, sram_dq_oe, mem_rdata);
    end
    mem_w_en = 0; #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: got %b expected 1", ready);
    end
    @(posedge clk); #1 rst = 0;
    rd_model = 32'h0;
    @(negedge clk);
    checks++;
    if ({ready, mem_rdata, sram_we_n} !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_after: ready=%b rdata=%h we_n=%b expected 1 0 1", ready, mem_rdata, sram_we_n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_align();
    do_access(0, 1, 32'd1026, 32'h0, "align_load");
    idle(1);
    do_access(0, 1, 32'd1032, 32'h0, "aligned_load");
    idle(1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = 16'(i * 37 + 4660);
      ref_mem[i] = 16'(i * 37 + 4660);
    end
    test_reset();
    test_no_request();
    test_store_default();
    test_load_default();
    test_back_to_back();
    test_wraparound();
    test_random();
    test_load_default();
    test_reset_mid();
    test_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory stage of the 5-stage ARM pipeline. Consumes the EX/MEM register outputs: ALU result as address, Rm value as store data, and the read/write enables.
- Performs each 32-bit load/store as two 16-bit accesses on the external SRAM.
- Drives ready low while busy. The top level freezes all pipeline registers with freeze = ~ready.
- Read data and a passthrough ALU result feed the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: data-memory base; SRAM byte offset = alu_res - BASE_ADDR.
- SRAM_WAIT, 2: clock cycles held per 16-bit SRAM access; legal range 1..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_r_en  in  1  load request, from EX/MEM.
- mem_w_en  in  1  store request, from EX/MEM.
- alu_res  in  32  byte address.
- val_rm  in  32  store data.
- ready  out  1  high = pipeline may advance.
- mem_rdata  out  32  load result, valid while ready is high after a load.
- alu_res_out  out  32  alu_res passed through combinationally.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data.
- sram_dq_oe  out  1  drive enable for the bidirectional bus (top level builds the tristate).
- sram_dq_in  in  16  read data from the pad.
- sram_we_n  out  1  active-low write strobe.

Behaviour:
- States: IDLE, LOW, HIGH, DONE. A 4-bit wait counter cnt runs within LOW and HIGH.
- Reset values:
  - state = IDLE, cnt = 0.
  - mem_rdata = 0, sram_addr = 0, sram_dq_out = 0.
  - sram_dq_oe = 0, sram_we_n = 1.
  - ready follows its combinational rule from IDLE.
- ready rule:
  - IDLE: ready = ~(mem_r_en | mem_w_en), combinational, so the stall takes effect in the same cycle the request appears.
  - LOW and HIGH: ready = 0.
  - DONE: ready = 1.
- IDLE transitions: any request → LOW with cnt = 0. If both enables are high, the store takes priority and mem_rdata is left unchanged.
- Address mapping: off = alu_res - BASE_ADDR, 32-bit wraparound subtract. word = off[SRAM_AW:2]. sram_addr = {word[SRAM_AW-2:0], half}, with half = 0 in LOW and 1 in HIGH. off[1:0] is ignored.
- Store, LOW/HIGH: sram_we_n = 0, sram_dq_oe = 1, sram_dq_out = val_rm[15:0] in LOW, val_rm[31:16] in HIGH.
- Load, LOW/HIGH: sram_we_n = 1, sram_dq_oe = 0.
- Per-half timing: each half lasts exactly SRAM_WAIT cycles. On the last cycle (cnt == SRAM_WAIT-1):
  - a load captures sram_dq_in into mem_rdata[15:0] (LOW) or mem_rdata[31:16] (HIGH);
  - cnt clears;
  - LOW → HIGH, HIGH → DONE.
- DONE: sram_we_n = 1, sram_dq_oe = 0. Next cycle → IDLE unconditionally. This single ready cycle lets EX/MEM load the next instruction, so the same request never re-issues.
- Stall length: 1 + 2*SRAM_WAIT cycles of ready = 0 per access (5 at default), then one ready cycle.
- Input stability: inputs are held stable by the freeze during LOW/HIGH. The block re-samples them every cycle and does not latch them.
- Reset mid-operation: returns to IDLE immediately. we_n goes high and oe goes low with no glitch to active; a partial mem_rdata is cleared.
- mem_rdata holds its value until the next load's capture.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - adds output misalign (1 bit), registered, reset 0;
  - set for the DONE cycle of an access whose alu_res[1:0] != 0;
  - the access still proceeds with the low bits ignored.
- Undefined: no misalign port; no extra logic.

Decomposition:
- Package mem_stage_pkg:
  - state enum (IDLE, LOW, HIGH, DONE);
  - default BASE_ADDR, SRAM_WAIT, SRAM_AW;
  - half-word width constant 16.
- One sub-module, sram_wait_counter:
  - ports: clk, rst, clear, limit;
  - outputs: last = (cnt == limit-1).
  - Instantiated once; the FSM remains in the top.

Test Plan:
- Store, defaults: alu_res=1024+8, val_rm=0xDEADBEEF, mem_w_en=1.
  - ready low 5 cycles.
  - sram_addr=4 with dq_out=0xBEEF and we_n=0 for 2 cycles, then sram_addr=5 with dq_out=0xDEAD.
  - ready high 1 cycle.
- Load, defaults: alu_res=1032, mem_r_en=1; bench SRAM model holds [4]=0xBEEF, [5]=0xDEAD.
  - After 5 stalled cycles, mem_rdata=0xDEADBEEF with ready=1.
  - oe=0 and we_n=1 throughout.
- Back-to-back: store then load on consecutive instructions.
  - Two separate stalls separated by exactly one ready cycle.
  - No duplicate SRAM write.
- No request: mem_r_en=mem_w_en=0 for 10 cycles.
  - ready constantly 1, we_n=1, state stays IDLE.
- Reset mid-store: assert rst during HIGH, second cycle.
  - Same cycle: we_n=1, oe=0.
  - After release: ready=1 when no request, mem_rdata=0.
- SRAM_WAIT=1 build plus MEM_ALIGN_CHECK_EN: load at alu_res=1026.
  - 3 stalled cycles; reads sram_addr 0 then 1.
  - misalign=1 only in the DONE cycle.
